unsaved_irq_ctrl: RTL and testbench

Avalon-MM interrupt controller that sits directly downstream of the system interval timer and the other peripheral IRQ sources. It collects up to 16 interrupt lines and latches them per source as level or rising-edge events. It masks them and drives one prioritised interrupt, with a source ID, to the CPU. Its 16-bit register slave uses the same bus conventions as the timer.

---
 rtl/unsaved_irq_ctrl_pkg.sv | 25 ++
 rtl/unsaved_irq_prio_enc.sv | 23 ++
 rtl/unsaved_irq_ctrl.sv | 121 ++++++++++++
 tb/tb_unsaved_irq_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/unsaved_irq_ctrl_pkg.sv
// Shared constants for unsaved_irq_ctrl: register word addresses, vector and ID widths,
// and a helper that builds the mask of implemented interrupt lines.
package unsaved_irq_ctrl_pkg;

    localparam int IRQ_MAX = 16;
    localparam int ID_W    = 4;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [2:0] ADDR_RAW      = 3'd4;
    localparam logic [2:0] ADDR_SWSET    = 3'd5;

    // Lines at or above num_irq read 0, cannot be set and never compete for priority.
    function automatic logic [IRQ_MAX-1:0] impl_mask(input int num_irq);
        logic [IRQ_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < IRQ_MAX; i++) begin
            if (i < num_irq) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/unsaved_irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set bit wins; idx is 0 when nothing is set.
module unsaved_irq_prio_enc
    import unsaved_irq_ctrl_pkg::*;
(
    input  logic [IRQ_MAX-1:0] vec,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        valid = 1'b0;
        idx   = '0;
        // Scanning downward lets the lowest-numbered set bit overwrite last.
        for (int i = IRQ_MAX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/unsaved_irq_ctrl.sv
// Avalon-MM interrupt controller: per-source level/edge latching, masking and a registered
// prioritised CPU interrupt with source ID. Define IRQ_CTRL_INPUT_SYNC_EN to add a 2-flop input synchroniser.
module unsaved_irq_ctrl
    import unsaved_irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [15:0]         writedata,
    output logic [15:0]         readdata,
    input  logic [NUM_IRQ-1:0]  irq_in,
    output logic                cpu_irq,
    output logic [ID_W-1:0]     cpu_irq_id
);

    localparam logic [IRQ_MAX-1:0] IMPL = impl_mask(NUM_IRQ);

    logic [IRQ_MAX-1:0] irq_ext;
    logic [IRQ_MAX-1:0] in_s;
    logic [IRQ_MAX-1:0] in_prev;
    logic [IRQ_MAX-1:0] pending;
    logic [IRQ_MAX-1:0] pending_next;
    logic [IRQ_MAX-1:0] mask;
    logic [IRQ_MAX-1:0] edge_sel;
    logic [IRQ_MAX-1:0] w1c;
    logic [IRQ_MAX-1:0] swset;
    logic [15:0]        rd_mux;
    logic               wr_en;
    logic               rd_en;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_idx;

    for (genvar g = 0; g < IRQ_MAX; g++) begin : g_ext
        if (g < NUM_IRQ) begin : g_used
            assign irq_ext[g] = irq_in[g];
        end else begin : g_tied
            assign irq_ext[g] = 1'b0;
        end
    end

`ifdef IRQ_CTRL_INPUT_SYNC_EN
    logic [IRQ_MAX-1:0] sync_q1;
    logic [IRQ_MAX-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_ext;
            sync_q2 <= sync_q1;
        end
    end

    assign in_s = sync_q2;
`else
    assign in_s = irq_ext;
`endif

    assign wr_en = chipselect && !write_n;
    assign rd_en = chipselect && write_n;
    assign w1c   = (wr_en && address == ADDR_PENDING) ? (writedata & IMPL) : '0;
    assign swset = (wr_en && address == ADDR_SWSET)   ? (writedata & IMPL) : '0;

    // A set (edge or SWSET) beats a same-cycle W1C, so an event is never dropped.
    always_comb begin
        pending_next = '0;
        for (int i = 0; i < IRQ_MAX; i++) begin
            if (edge_sel[i]) begin
                pending_next[i] = (pending[i] & ~w1c[i]) | (in_s[i] & ~in_prev[i]) | swset[i];
            end else begin
                pending_next[i] = in_s[i];
            end
        end
        pending_next = pending_next & IMPL;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_PENDING:  rd_mux = pending;
            ADDR_MASK:     rd_mux = mask;
            ADDR_EDGE_SEL: rd_mux = edge_sel;
            ADDR_ACTIVE:   rd_mux = {cpu_irq, 11'd0, cpu_irq_id};
            ADDR_RAW:      rd_mux = in_s;
            default:       rd_mux = '0;
        endcase
    end

    unsaved_irq_prio_enc u_prio_enc (
        .vec   (pending & mask),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            in_prev    <= '0;
            pending    <= '0;
            mask       <= '0;
            edge_sel   <= '0;
            readdata   <= '0;
            cpu_irq    <= 1'b0;
            cpu_irq_id <= '0;
        end else begin
            in_prev    <= in_s;
            pending    <= pending_next;
            cpu_irq    <= enc_valid;
            cpu_irq_id <= enc_idx;
            if (wr_en && address == ADDR_MASK)     mask     <= writedata & IMPL;
            if (wr_en && address == ADDR_EDGE_SEL) edge_sel <= writedata & IMPL;
            if (rd_en)                             readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_unsaved_irq_ctrl.sv
// Directed self-checking bench for unsaved_irq_ctrl (NUM_IRQ = 8); latencies adapt to IRQ_CTRL_INPUT_SYNC_EN.
module tb_unsaved_irq_ctrl;

    localparam int NUM_IRQ = 8;
`ifdef IRQ_CTRL_INPUT_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = SYNC + 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [2:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [15:0]        writedata;
    logic [15:0]        readdata;
    logic [NUM_IRQ-1:0] irq_in;
    logic               cpu_irq;
    logic [3:0]         cpu_irq_id;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] rd;

    unsaved_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .cpu_irq    (cpu_irq),
        .cpu_irq_id (cpu_irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        tick();
        d = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; irq_in = '0;
        ticks(3);
        reset_n = 1'b1;
        tick();

        // Reset state
        check("reset_cpu_irq", {15'd0, cpu_irq}, 16'h0);
        check("reset_irq_id", {12'd0, cpu_irq_id}, 16'h0);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("reset_read_a%0d", a), rd, 16'h0000);
        end

        // Level source 0
        bus_write(3'd1, 16'h0001);
        irq_in[0] = 1'b1;
        ticks(LAT - 1);
        check("lvl_irq_early", {15'd0, cpu_irq}, 16'h0);
        tick();
        check("lvl_irq_set", {15'd0, cpu_irq}, 16'h1);
        check("lvl_id", {12'd0, cpu_irq_id}, 16'h0);
        bus_write(3'd0, 16'h0001);
        bus_read(3'd0, rd);
        check("lvl_w1c_noeffect", rd, 16'h0001);
        check("lvl_irq_after_w1c", {15'd0, cpu_irq}, 16'h1);
        irq_in[0] = 1'b0;
        ticks(LAT - 1);
        check("lvl_drop_early", {15'd0, cpu_irq}, 16'h1);
        tick();
        check("lvl_drop", {15'd0, cpu_irq}, 16'h0);

        // Edge source 2, single-cycle pulse
        bus_write(3'd2, 16'h0004);
        bus_write(3'd1, 16'h0004);
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        ticks(LAT + 1);
        check("edge_irq", {15'd0, cpu_irq}, 16'h1);
        check("edge_id", {12'd0, cpu_irq_id}, 16'h2);
        bus_read(3'd0, rd);
        check("edge_pending", rd, 16'h0004);
        bus_write(3'd0, 16'h0004);
        check("edge_w1c_irq_at_W", {15'd0, cpu_irq}, 16'h1);
        tick();
        check("edge_w1c_irq_W1", {15'd0, cpu_irq}, 16'h0);
        bus_read(3'd0, rd);
        check("edge_w1c_pending", rd, 16'h0000);

        // Edge source 3: W1C in the same cycle as a new rising edge
        bus_write(3'd2, 16'h0008);
        irq_in[3] = 1'b1;
        ticks(LAT);
        irq_in[3] = 1'b0;
        ticks(LAT);
        bus_read(3'd0, rd);
        check("edge3_first", rd, 16'h0008);
        irq_in[3] = 1'b1;
        ticks(SYNC);
        bus_write(3'd0, 16'h0008);
        bus_read(3'd0, rd);
        check("edge3_set_wins", rd, 16'h0008);
        bus_write(3'd0, 16'h0008);
        bus_read(3'd0, rd);
        check("edge3_plain_w1c", rd, 16'h0000);
        irq_in[3] = 1'b0;

        // Priority between level bits 1 and 5
        bus_write(3'd2, 16'h0000);
        irq_in[1] = 1'b1;
        irq_in[5] = 1'b1;
        bus_write(3'd1, 16'h0022);
        ticks(LAT + 1);
        check("prio_irq", {15'd0, cpu_irq}, 16'h1);
        check("prio_id1", {12'd0, cpu_irq_id}, 16'h1);
        bus_write(3'd1, 16'h0020);
        check("prio_id_at_W", {12'd0, cpu_irq_id}, 16'h1);
        tick();
        check("prio_id5", {12'd0, cpu_irq_id}, 16'h5);
        bus_read(3'd3, rd);
        check("active_read", rd, 16'h8005);
        bus_read(3'd4, rd);
        check("raw_read", rd, 16'h0022);

        // SWSET on edge source 7, unused addresses, masked writes, then reset
        irq_in = '0;
        bus_write(3'd2, 16'h0080);
        bus_write(3'd1, 16'h0080);
        ticks(LAT + 1);
        bus_write(3'd5, 16'h0080);
        bus_read(3'd0, rd);
        check("swset_pending", rd, 16'h0080);
        check("swset_irq", {15'd0, cpu_irq}, 16'h1);
        check("swset_id", {12'd0, cpu_irq_id}, 16'h7);
        bus_read(3'd5, rd);
        check("swset_reads0", rd, 16'h0000);
        bus_write(3'd6, 16'hFFFF);
        bus_read(3'd6, rd);
        check("addr6_read", rd, 16'h0000);
        bus_write(3'd1, 16'hFFFF);
        bus_read(3'd1, rd);
        check("mask_impl_bits", rd, 16'h00FF);
        reset_n = 1'b0;
        tick();
        check("rst_cpu_irq", {15'd0, cpu_irq}, 16'h0);
        check("rst_id", {12'd0, cpu_irq_id}, 16'h0);
        check("rst_readdata", readdata, 16'h0000);
        reset_n = 1'b1;
        bus_read(3'd0, rd);
        check("rst_pending", rd, 16'h0000);
        bus_read(3'd1, rd);
        check("rst_mask", rd, 16'h0000);
        bus_read(3'd2, rd);
        check("rst_edge_sel", rd, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
